wb_arbiter: RTL

- Owns the single write port of the core's 32x32 register file and shares it between two requesters: ALU writeback and AXI-lite load responses.
- Keeps a per-register scoreboard of outstanding loads and provides busy flags so decode can stall on RAW hazards.
- The arbiter itself holds ALU writes to a register until the outstanding load to it retires (WAW).
- Sits between execute/LSU and the register file write inputs.

---
 rtl/wb_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between ALU writeback and load responses.
// It also keeps the outstanding-load scoreboard that drives the decode busy flags.
module wb_arbiter #(
    parameter int MAX_LOADS = 4,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_wb_valid,
    output logic             alu_wb_ready,
    input  logic [4:0]       alu_rd_addr,
    input  logic [31:0]      alu_wb_data,
    input  logic             ld_issue_valid,
    output logic             ld_issue_ready,
    input  logic [4:0]       ld_issue_rd,
    input  logic             ld_rsp_valid,
    output logic             ld_rsp_ready,
    input  logic [4:0]       ld_rsp_rd,
    input  logic [31:0]      ld_rsp_data,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             RegWrite,
    output logic [4:0]       rd_addr,
    output logic [31:0]      write_data,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             err_stale
);

    typedef enum logic {GRANT_ALU = 1'b0, GRANT_LD = 1'b1} grant_t;

    grant_t      last_grant;
    logic [31:0] busy;
    logic [31:0] busy_next;
    logic        alu_elig;
    logic        ld_elig;
    logic        alu_xfer;
    logic        rsp_xfer;
    logic        issue_xfer;
    logic        rsp_live;
    logic        rsp_stale;
    logic        cnt_inc;
    logic        cnt_dec;

    // An ALU write to a register with a load in flight waits for that load (WAW).
    assign alu_elig = alu_wb_valid && !busy[alu_rd_addr];
    assign ld_elig  = ld_rsp_valid;

    assign alu_wb_ready = alu_elig && (!ld_elig || last_grant == GRANT_LD);
    assign ld_rsp_ready = ld_elig && (!alu_elig || last_grant == GRANT_ALU);
    assign ld_issue_ready = (pending_cnt < CNT_W'(MAX_LOADS)) &&
                            (ld_issue_rd == 5'd0 || !busy[ld_issue_rd]);

    assign alu_xfer   = alu_wb_valid && alu_wb_ready;
    assign rsp_xfer   = ld_rsp_valid && ld_rsp_ready;
    assign issue_xfer = ld_issue_valid && ld_issue_ready;

    assign rsp_live  = (ld_rsp_rd != 5'd0) && busy[ld_rsp_rd];
    assign rsp_stale = (ld_rsp_rd != 5'd0) && !busy[ld_rsp_rd];

    // x0 loads are tracked by count only, so their responses just decrement.
    assign cnt_inc = issue_xfer;
    assign cnt_dec = rsp_xfer && (rsp_live || (ld_rsp_rd == 5'd0 && pending_cnt != '0));

    always_comb begin
        busy_next = busy;
        if (rsp_xfer && rsp_live) begin
            busy_next[ld_rsp_rd] = 1'b0;
        end
        if (issue_xfer && ld_issue_rd != 5'd0) begin
            busy_next[ld_issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= GRANT_ALU;
            busy        <= '0;
            pending_cnt <= '0;
            RegWrite    <= 1'b0;
            rd_addr     <= 5'd0;
            write_data  <= 32'd0;
            err_stale   <= 1'b0;
        end else begin
            busy      <= busy_next;
            err_stale <= rsp_xfer && rsp_stale;

            if (cnt_inc && !cnt_dec) begin
                pending_cnt <= pending_cnt + CNT_W'(1);
            end else if (cnt_dec && !cnt_inc) begin
                pending_cnt <= pending_cnt - CNT_W'(1);
            end

            if (alu_xfer) begin
                last_grant <= GRANT_ALU;
                RegWrite   <= (alu_rd_addr != 5'd0);
                rd_addr    <= alu_rd_addr;
                write_data <= alu_wb_data;
            end else if (rsp_xfer) begin
                last_grant <= GRANT_LD;
                RegWrite   <= rsp_live;
                rd_addr    <= ld_rsp_rd;
                write_data <= ld_rsp_data;
            end else begin
                RegWrite   <= 1'b0;
            end
        end
    end

    // The register file commits one edge after RegWrite, so the in-flight write counts as busy.
    assign rs1_busy = (rs1_addr != 5'd0) && (busy[rs1_addr] || (RegWrite && rd_addr == rs1_addr));
    assign rs2_busy = (rs2_addr != 5'd0) && (busy[rs2_addr] || (RegWrite && rd_addr == rs2_addr));

endmodule
